axis_packetizer: RTL and testbench

Frames an unframed word stream into AXI-Stream packets of a programmable beat count and drives them out as an AXI-Stream master. This is the transmit end of the stream loopback path: it sources packetised data with `tlast` framing, for example encoder output words headed to DMA. A 2-entry output buffer sustains one beat per cycle under continuous `m_axis_tready`. A frame can also end early through `s_eof`.

---
 rtl/axis_packetizer_pkg.sv | 12 +
 rtl/axis_skid_buffer.sv | 72 +++++++
 rtl/axis_packetizer.sv | 119 +++++++++++
 tb/tb_axis_packetizer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_packetizer_pkg.sv
// Shared types and constants for the AXI-Stream packetizer.
package axis_packetizer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  localparam int PKT_CNT_W = 16;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry register slice (main + skid). in_ready depends only on the skid
// register, so there is no combinational path from out_ready to in_ready.
module axis_skid_buffer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [DATA_WIDTH:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [DATA_WIDTH:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                full,
  output logic                empty
);

  logic                main_vld_q, main_vld_d;
  logic                skid_vld_q, skid_vld_d;
  logic [DATA_WIDTH:0] main_q, main_d;
  logic [DATA_WIDTH:0] skid_q, skid_d;
  logic                push, pop;

  assign in_ready  = !skid_vld_q;
  assign push      = in_valid && in_ready;
  assign pop       = main_vld_q && out_ready;
  assign out_valid = main_vld_q;
  assign out_data  = main_q;
  assign full      = skid_vld_q;
  assign empty     = !main_vld_q && !skid_vld_q;

  always_comb begin
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    main_d     = main_q;
    skid_d     = skid_q;
    if (pop) begin
      // A push is impossible while skid is occupied, so the two cases are exclusive.
      if (skid_vld_q) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else if (push) begin
        main_d = in_data;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (push) begin
      if (!main_vld_q) begin
        main_d     = in_data;
        main_vld_d = 1'b1;
      end else begin
        skid_d     = in_data;
        skid_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else begin
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
    end
  end

endmodule

// File: rtl/axis_packetizer.sv
// Frames an unframed word stream into fixed-length AXI-Stream packets with
// tlast, ending a frame early on s_eof or at a packet boundary when cfg_en drops.
module axis_packetizer
  import axis_packetizer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cfg_en,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_eof,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic [PKT_CNT_W-1:0]  pkt_count,
  output logic                  frame_done
);

  function automatic logic [LEN_WIDTH-1:0] clamp_len(input logic [LEN_WIDTH-1:0] len);
    return (len == '0) ? LEN_WIDTH'(1) : len;
  endfunction

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [PKT_CNT_W-1:0] pkt_count_q, pkt_count_d;
  logic                 frame_done_q, frame_done_d;

  logic                  in_xfer, tlast_in, out_xfer;
  logic                  buf_in_ready, buf_full, buf_empty;
  logic [DATA_WIDTH:0]   buf_out;

  assign s_ready  = (state_q == ACTIVE) && !buf_full;
  assign in_xfer  = s_valid && s_ready && buf_in_ready;
  assign tlast_in = (beat_cnt_q == (len_q - LEN_WIDTH'(1))) || s_eof;
  assign out_xfer = m_axis_tvalid && m_axis_tready;

  axis_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .in_data  ({tlast_in, s_data}),
    .in_valid (in_xfer),
    .in_ready (buf_in_ready),
    .out_data (buf_out),
    .out_valid(m_axis_tvalid),
    .out_ready(m_axis_tready),
    .full     (buf_full),
    .empty    (buf_empty)
  );

  assign m_axis_tdata = buf_out[DATA_WIDTH-1:0];
  assign m_axis_tlast = buf_out[DATA_WIDTH];
  assign busy         = (state_q != IDLE);
  assign pkt_count    = pkt_count_q;
  assign frame_done   = frame_done_q;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    beat_cnt_d   = beat_cnt_q;
    pkt_count_d  = pkt_count_q;
    frame_done_d = 1'b0;
    if (out_xfer && m_axis_tlast) pkt_count_d = pkt_count_q + PKT_CNT_W'(1);
    case (state_q)
      IDLE: begin
        if (cfg_en) begin
          state_d    = ACTIVE;
          len_d      = clamp_len(cfg_len);
          beat_cnt_d = '0;
        end
      end
      ACTIVE: begin
        if (in_xfer) begin
          // cfg_len is sampled only at packet boundaries; cfg_en only ends the frame there.
          if (tlast_in) begin
            beat_cnt_d = '0;
            len_d      = clamp_len(cfg_len);
            if (s_eof || !cfg_en) state_d = DRAIN;
          end else begin
            beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        if (buf_empty) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      len_q        <= '0;
      beat_cnt_q   <= '0;
      pkt_count_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      beat_cnt_q   <= beat_cnt_d;
      pkt_count_q  <= pkt_count_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_axis_packetizer.sv
// Directed bench for axis_packetizer: framing, backpressure, length edge cases,
// enable drop and asynchronous reset mid-packet.
module tb_axis_packetizer;

  localparam int DW = 32;
  localparam int LW = 16;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          cfg_en = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic [DW-1:0] s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          s_eof = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          busy;
  logic [15:0]   pkt_count;
  logic          frame_done;

  logic bp_mode = 1'b0;
  logic bp_phase = 1'b0;
  logic hold_low = 1'b0;

  assign m_axis_tready = hold_low ? 1'b0 : (bp_mode ? bp_phase : 1'b1);

  axis_packetizer #(
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .cfg_en       (cfg_en),
    .cfg_len      (cfg_len),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_eof        (s_eof),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .busy         (busy),
    .pkt_count    (pkt_count),
    .frame_done   (frame_done)
  );

  always #5 aclk = ~aclk;

  always @(negedge aclk) bp_phase = ~bp_phase;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Output monitor: samples 2 time units after the falling edge, well away from the rising edge.
  logic [DW-1:0] obs_d[$];
  logic          obs_l[$];
  int            obs_cyc[$];
  int            cyc = 0;
  int            fd_cnt = 0;
  int            inflight = 0;
  logic          stall_q = 1'b0;
  logic [DW:0]   stall_beat = '0;

  always begin
    @(negedge aclk);
    #2;
    cyc++;
    if (!aresetn) begin
      inflight = 0;
      stall_q  = 1'b0;
    end else begin
      if (frame_done) fd_cnt++;
      if (stall_q) begin
        check("stall_valid", 64'(m_axis_tvalid), 64'(1));
        check("stall_hold", 64'({m_axis_tlast, m_axis_tdata}), 64'(stall_beat));
      end
      if (inflight == 2) check("full_sready", 64'(s_ready), 64'(0));
      if (m_axis_tvalid && m_axis_tready) begin
        obs_d.push_back(m_axis_tdata);
        obs_l.push_back(m_axis_tlast);
        obs_cyc.push_back(cyc);
      end
      stall_q    = m_axis_tvalid && !m_axis_tready;
      stall_beat = {m_axis_tlast, m_axis_tdata};
      inflight   = inflight + int'(s_valid && s_ready) - int'(m_axis_tvalid && m_axis_tready);
    end
  end

  task automatic push_word(input logic [DW-1:0] d, input logic eof);
    int budget;
    budget  = 100;
    s_data  = d;
    s_valid = 1'b1;
    s_eof   = eof;
    while (!s_ready && budget > 0) begin
      @(negedge aclk);
      budget--;
    end
    if (budget == 0) check("push_timeout", 64'(0), 64'(1));
    @(negedge aclk);
  endtask

  task automatic end_input();
    s_valid = 1'b0;
    s_eof   = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int budget;
    budget = 200;
    while (busy && budget > 0) begin
      @(negedge aclk);
      budget--;
    end
    if (budget == 0) check({tag, "_idle_timeout"}, 64'(0), 64'(1));
    repeat (3) @(negedge aclk);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    cfg_en  = 1'b0;
    end_input();
    bp_mode  = 1'b0;
    hold_low = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    obs_d.delete();
    obs_l.delete();
    obs_cyc.delete();
    fd_cnt = 0;
    @(negedge aclk);
  endtask

  task automatic check_stream(input string tag, input int n, input logic [DW-1:0] base,
                              input logic [31:0] mask);
    check({tag, "_len"}, 64'(obs_d.size()), 64'(n));
    for (int i = 0; i < n && i < obs_d.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), 64'({obs_l[i], obs_d[i]}),
            64'({mask[i], base + DW'(i)}));
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge aclk);
    check("rst_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("rst_tdata", 64'(m_axis_tdata), 64'(0));
    check("rst_tlast", 64'(m_axis_tlast), 64'(0));
    check("rst_sready", 64'(s_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_pktcnt", 64'(pkt_count), 64'(0));
    check("rst_fdone", 64'(frame_done), 64'(0));
    aresetn = 1'b1;
    @(negedge aclk);
    check("idle_sready", 64'(s_ready), 64'(0));

    // Basic framing: len 4, words 0..9, eof on 9
    cfg_len = 16'd4;
    cfg_en  = 1'b1;
    @(negedge aclk);
    for (int i = 0; i < 10; i++) push_word(DW'(i), i == 9);
    end_input();
    cfg_en = 1'b0;
    wait_idle("basic");
    check_stream("basic", 10, 32'd0, 32'h288);
    if (obs_cyc.size() == 10) check("basic_rate", 64'(obs_cyc[9] - obs_cyc[0]), 64'(9));
    else check("basic_rate_n", 64'(obs_cyc.size()), 64'(10));
    check("basic_pktcnt", 64'(pkt_count), 64'(3));
    check("basic_fdone", 64'(fd_cnt), 64'(1));
    check("basic_busy", 64'(busy), 64'(0));

    // Backpressure: tready toggles, len 5, 20 words
    do_reset();
    bp_mode = 1'b1;
    cfg_len = 16'd5;
    cfg_en  = 1'b1;
    @(negedge aclk);
    for (int i = 0; i < 20; i++) push_word(DW'(i), i == 19);
    end_input();
    cfg_en = 1'b0;
    wait_idle("bp");
    bp_mode = 1'b0;
    check_stream("bp", 20, 32'd0, 32'h84210);
    check("bp_pktcnt", 64'(pkt_count), 64'(4));
    check("bp_fdone", 64'(fd_cnt), 64'(1));

    // Length 0 treated as 1
    do_reset();
    cfg_len = 16'd0;
    cfg_en  = 1'b1;
    @(negedge aclk);
    for (int i = 0; i < 3; i++) push_word(32'h100 + DW'(i), i == 2);
    end_input();
    cfg_en = 1'b0;
    wait_idle("len0");
    check_stream("len0", 3, 32'h100, 32'h7);
    check("len0_pktcnt", 64'(pkt_count), 64'(3));

    // Length change mid-packet: applies from the next packet
    do_reset();
    cfg_len = 16'd4;
    cfg_en  = 1'b1;
    @(negedge aclk);
    push_word(32'h200, 1'b0);
    push_word(32'h201, 1'b0);
    cfg_len = 16'd2;
    for (int i = 2; i < 10; i++) push_word(32'h200 + DW'(i), i == 9);
    end_input();
    cfg_en = 1'b0;
    wait_idle("lenchg");
    check_stream("lenchg", 10, 32'h200, 32'h2A8);
    check("lenchg_pktcnt", 64'(pkt_count), 64'(4));

    // Enable dropped mid-packet: packet completes, then the frame ends
    do_reset();
    cfg_len = 16'd4;
    cfg_en  = 1'b1;
    @(negedge aclk);
    push_word(32'h300, 1'b0);
    push_word(32'h301, 1'b0);
    cfg_en = 1'b0;
    push_word(32'h302, 1'b0);
    push_word(32'h303, 1'b0);
    check("endrop_sready", 64'(s_ready), 64'(0));
    check("endrop_busy_drain", 64'(busy), 64'(1));
    end_input();
    wait_idle("endrop");
    check_stream("endrop", 4, 32'h300, 32'h8);
    check("endrop_pktcnt", 64'(pkt_count), 64'(1));
    check("endrop_fdone", 64'(fd_cnt), 64'(1));
    check("endrop_busy", 64'(busy), 64'(0));
    check("endrop_sready_idle", 64'(s_ready), 64'(0));

    // Asynchronous reset mid-packet
    do_reset();
    hold_low = 1'b1;
    cfg_len  = 16'd4;
    cfg_en   = 1'b1;
    @(negedge aclk);
    push_word(32'hA0, 1'b0);
    check("arst_pre_tvalid", 64'(m_axis_tvalid), 64'(1));
    #1;
    aresetn = 1'b0;
    #1;
    check("arst_tvalid", 64'(m_axis_tvalid), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_sready", 64'(s_ready), 64'(0));
    end_input();
    cfg_en   = 1'b0;
    hold_low = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    obs_d.delete();
    obs_l.delete();
    obs_cyc.delete();
    fd_cnt  = 0;
    cfg_len = 16'd2;
    cfg_en  = 1'b1;
    @(negedge aclk);
    push_word(32'hB0, 1'b0);
    push_word(32'hB1, 1'b0);
    push_word(32'hB2, 1'b1);
    end_input();
    cfg_en = 1'b0;
    wait_idle("arst");
    check_stream("arst", 3, 32'hB0, 32'h6);
    check("arst_pktcnt", 64'(pkt_count), 64'(2));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
